multi_button_shaper: RTL and testbench

MULTI_BUTTON_SHAPER -- requirements
Module: multi_button_shaper

---
 rtl/button_pkg.sv | 27 ++
 rtl/button_channel.sv | 148 ++++++++++++++
 rtl/multi_button_shaper.sv | 50 +++++
 tb/tb_multi_button_shaper.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
//   Shared definitions for the multi-button shaper:
//     - btn_state_e : per-channel debounce / auto-repeat FSM states
//     - cnt_width() : width of a counter that must hold the largest of the
//                     debounce, repeat-delay and repeat-rate intervals
// -----------------------------------------------------------------------------
package button_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DEB_PRESS = 3'd1,
    S_PRESSED   = 3'd2,
    S_REPEAT    = 3'd3,
    S_DEB_REL   = 3'd4
  } btn_state_e;

  // Width of a counter able to represent max(a, b, c).
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage : button_pkg

// File: rtl/button_channel.sv
// -----------------------------------------------------------------------------
// button_channel
//   One button: 2-flop synchronizer, debounce / auto-repeat FSM and a shared
//   saturating interval counter.
//
//   Ports
//     clk      : system clock, rising edge
//     rst_n    : asynchronous active-low reset
//     btn_n_i  : raw asynchronous button, active-low (0 = pressed)
//     press_o  : one-cycle pulse on accepted press and on every repeat
//     held_o   : debounced pressed level
//     rel_o    : one-cycle pulse on accepted release
// -----------------------------------------------------------------------------
module button_channel
  import button_pkg::*;
#(
  parameter int DEB_CYCLES   = 16,
  parameter int REPEAT_EN    = 1,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n_i,
  output logic press_o,
  output logic held_o,
  output logic rel_o
);

  localparam int CW = cnt_width(DEB_CYCLES, REPEAT_DELAY, REPEAT_RATE);

  // Terminal counts: the counter starts at 0 on entry to a state, so the
  // N-th qualifying sample is the one taken while it reads N-1.
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE - 1);
  localparam logic [CW-1:0] CNT_MAX    = '1;

  btn_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          from_rep_q, from_rep_d;  // S_DEB_REL was entered from S_REPEAT
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          btn_low;

  assign btn_low = ~sync2_q;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    sync1_d    = btn_n_i;
    sync2_d    = sync1_q;
    state_d    = state_q;
    from_rep_d = from_rep_q;
    press_d    = 1'b0;
    rel_d      = 1'b0;
    // Saturate rather than wrap: in S_PRESSED with repeat disabled the
    // counter keeps running for as long as the button is held.
    cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (btn_low) state_d = S_DEB_PRESS;
      end

      S_DEB_PRESS: begin
        if (!btn_low) begin
          state_d = S_IDLE;        // glitch rejected, no pulse
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = S_PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end
      end

      S_PRESSED: begin
        if (!btn_low) begin
          state_d    = S_DEB_REL;
          cnt_d      = '0;
          from_rep_d = 1'b0;
        end else if ((REPEAT_EN != 0) && (cnt_q == DELAY_LAST)) begin
          state_d = S_REPEAT;
          cnt_d   = '0;
          press_d = 1'b1;
        end
      end

      S_REPEAT: begin
        if (!btn_low) begin
          state_d    = S_DEB_REL;
          cnt_d      = '0;
          from_rep_d = 1'b1;
        end else if (cnt_q == RATE_LAST) begin
          cnt_d   = '0;
          press_d = 1'b1;
        end
      end

      S_DEB_REL: begin
        if (btn_low) begin
          // Release bounce: resume where we were with a fresh repeat interval.
          state_d = from_rep_q ? S_REPEAT : S_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          rel_d   = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b1;  // idle (released) level, so reset never looks like a press
      sync2_q    <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      from_rep_q <= 1'b0;
      press_q    <= 1'b0;
      rel_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      from_rep_q <= from_rep_d;
      press_q    <= press_d;
      rel_q      <= rel_d;
    end
  end

  assign press_o = press_q;
  assign rel_o   = rel_q;
  assign held_o  = (state_q inside {S_PRESSED, S_REPEAT, S_DEB_REL});

endmodule : button_channel

// File: rtl/multi_button_shaper.sv
// -----------------------------------------------------------------------------
// multi_button_shaper
//   N_BTN independent debounced buttons with optional auto-repeat.
//
//   Ports
//     clk   : system clock, rising edge
//     rst   : asynchronous active-low reset
//     bIN   : raw asynchronous buttons, active-low (0 = pressed)
//     bOUT  : one-cycle press pulse per channel (accepted press and repeats)
//     bHELD : debounced pressed level per channel
//     bREL  : one-cycle pulse per channel on accepted release
//     bANY  : OR of all bOUT bits, same cycle
// -----------------------------------------------------------------------------
module multi_button_shaper
  import button_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int DEB_CYCLES   = 16,
  parameter int REPEAT_EN    = 1,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] bIN,
  output logic [N_BTN-1:0] bOUT,
  output logic [N_BTN-1:0] bHELD,
  output logic [N_BTN-1:0] bREL,
  output logic             bANY
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    button_channel #(
      .DEB_CYCLES   (DEB_CYCLES),
      .REPEAT_EN    (REPEAT_EN),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst),
      .btn_n_i (bIN[g]),
      .press_o (bOUT[g]),
      .held_o  (bHELD[g]),
      .rel_o   (bREL[g])
    );
  end

  assign bANY = |bOUT;

endmodule : multi_button_shaper

// File: tb/tb_multi_button_shaper.sv
// -----------------------------------------------------------------------------
// tb_multi_button_shaper
//   Directed stimulus with a cycle-stamped scoreboard. Each stimulus step
//   pushes the output events it must cause (cycle, press/release pulses,
//   held set/clear); a negedge monitor pops the events for the current cycle
//   and compares every output every cycle.
//   Timing rule: an input change driven at the negedge of cycle c is first
//   sampled at edge c+1, and its debounced effect appears in cycle c+7
//   (2 synchronizer edges + DEB_CYCLES=4 + 1).
// -----------------------------------------------------------------------------
module tb_multi_button_shaper;

  localparam int NB = 4;

  typedef struct {
    int             cyc;
    logic [NB-1:0]  out;
    logic [NB-1:0]  rel;
    logic [NB-1:0]  hset;
    logic [NB-1:0]  hclr;
  } sb_ev_t;

  logic          clk;
  logic          rst;
  logic [NB-1:0] bIN;
  logic [NB-1:0] bOUT;
  logic [NB-1:0] bHELD;
  logic [NB-1:0] bREL;
  logic          bANY;

  int            cyc = 0;
  int            n_vec = 0;
  int            n_err = 0;
  sb_ev_t        sb_q[$];
  logic [NB-1:0] exp_held = '0;
  logic [NB-1:0] mon_out;
  logic [NB-1:0] mon_rel;

  multi_button_shaper #(
    .N_BTN        (NB),
    .DEB_CYCLES   (4),
    .REPEAT_EN    (1),
    .REPEAT_DELAY (10),
    .REPEAT_RATE  (5)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bIN   (bIN),
    .bOUT  (bOUT),
    .bHELD (bHELD),
    .bREL  (bREL),
    .bANY  (bANY)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_vec++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Scoreboard monitor: compare all outputs every cycle, away from the edge.
  always @(negedge clk) begin
    mon_out = '0;
    mon_rel = '0;
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc == cyc) begin
        mon_out  = mon_out | sb_q[i].out;
        mon_rel  = mon_rel | sb_q[i].rel;
        exp_held = (exp_held | sb_q[i].hset) & ~sb_q[i].hclr;
        sb_q.delete(i);
      end else if (sb_q[i].cyc < cyc) begin
        check("sb_stale_event", 8'(sb_q[i].cyc), 8'(cyc));
        sb_q.delete(i);
      end
    end
    check("bOUT",  8'(bOUT),  8'(mon_out));
    check("bREL",  8'(bREL),  8'(mon_rel));
    check("bHELD", 8'(bHELD), 8'(exp_held));
    check("bANY",  8'(bANY),  8'(|mon_out));
  end

  task automatic push(input int t, input logic [NB-1:0] o, input logic [NB-1:0] r,
                      input logic [NB-1:0] hs, input logic [NB-1:0] hc);
    sb_q.push_back('{cyc: t, out: o, rel: r, hset: hs, hclr: hc});
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Press channels in mask now; returns the cycle the accept pulse appears.
  task automatic press(input logic [NB-1:0] m, output int acc);
    acc = cyc + 7;
    push(acc, m, '0, m, '0);
    bIN = bIN & ~m;
  endtask

  // Final (clean) release of channels in mask now.
  task automatic release_btn(input logic [NB-1:0] m);
    push(cyc + 7, '0, m, '0, m);
    bIN = bIN | m;
  endtask

  initial begin
    int a;
    rst = 1'b0;
    bIN = '1;
    repeat (3) @(negedge clk);
    check("reset_bOUT",  8'(bOUT),  8'h00);
    check("reset_bHELD", 8'(bHELD), 8'h00);
    check("reset_bREL",  8'(bREL),  8'h00);
    check("reset_bANY",  8'(bANY),  8'h00);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Basic press latency on channel 0, short hold (no repeat), clean release.
    press(4'b0001, a);
    wait_until(a + 3);
    release_btn(4'b0001);
    wait_until(a + 16);

    // Glitches on channel 1: 3 and 4 low samples rejected, 5 accepted.
    bIN[1] = 1'b0;
    repeat (3) @(negedge clk);
    bIN[1] = 1'b1;
    repeat (10) @(negedge clk);
    bIN[1] = 1'b0;
    repeat (4) @(negedge clk);
    bIN[1] = 1'b1;
    repeat (10) @(negedge clk);
    press(4'b0010, a);
    repeat (5) @(negedge clk);
    release_btn(4'b0010);
    repeat (14) @(negedge clk);

    // Auto-repeat on channel 2: accept, +10, +15, +20, +25, +30.
    press(4'b0100, a);
    for (int k = 10; k <= 30; k += 5) push(a + k, 4'b0100, '0, '0, '0);
    wait_until(a + 31);
    release_btn(4'b0100);
    wait_until(a + 45);

    // Release bounce on channel 3: 2 cycles high, 2 low, then stable high.
    // The bounce returns to S_PRESSED with a fresh repeat interval, so no
    // repeat pulse at accept+10.
    press(4'b1000, a);
    wait_until(a + 6);
    bIN[3] = 1'b1;
    wait_until(a + 8);
    bIN[3] = 1'b0;
    wait_until(a + 10);
    release_btn(4'b1000);
    wait_until(a + 25);

    // Simultaneous press on channels 0 and 3.
    press(4'b1001, a);
    wait_until(a + 2);
    release_btn(4'b1001);
    wait_until(a + 15);

    // Reset during S_REPEAT with channel 1 still held, then re-accept.
    press(4'b0010, a);
    push(a + 10, 4'b0010, '0, '0, '0);
    wait_until(a + 12);
    #2;
    rst = 1'b0;
    sb_q.delete();
    exp_held = '0;
    #1;
    check("rst_async_bOUT",  8'(bOUT),  8'h00);
    check("rst_async_bHELD", 8'(bHELD), 8'h00);
    check("rst_async_bREL",  8'(bREL),  8'h00);
    check("rst_async_bANY",  8'(bANY),  8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    a = cyc + 7;
    push(a, 4'b0010, '0, 4'b0010, '0);
    wait_until(a + 3);
    release_btn(4'b0010);
    wait_until(a + 16);

    check("sb_drained", 8'(sb_q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_multi_button_shaper
